// File: rtl/ibex_dummy_reseed_ctrl_pkg.sv
// Shared types for the dummy-instruction reseed controller.
package ibex_dummy_reseed_ctrl_pkg;

  localparam int unsigned DummySeedW = 32;

  typedef enum logic [1:0] {
    RESEED_IDLE  = 2'd0,
    RESEED_REQ   = 2'd1,
    RESEED_APPLY = 2'd2
  } reseed_state_e;

endpackage

// File: rtl/ibex_dummy_reseed_cnt.sv
// Up-counter with synchronous clear that holds once it reaches MaxVal.
// Used both as the reseed interval counter and as the saturating statistics counter.
module ibex_dummy_reseed_cnt #(
  parameter int unsigned      Width  = 8,
  parameter logic [Width-1:0] MaxVal = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] count
);

  logic [Width-1:0] cnt_r;
  logic [Width-1:0] cnt_d_s;

  // Next count: clear has priority, increment stops at MaxVal.
  always_comb begin
    cnt_d_s = cnt_r;
    if (clr) begin
      cnt_d_s = '0;
    end else if (inc && (cnt_r != MaxVal)) begin
      cnt_d_s = cnt_r + 1'b1;
    end else begin
      cnt_d_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_d_s;
    end
  end

  assign count = cnt_r;

endmodule

// File: rtl/ibex_dummy_reseed_ctrl.sv
// Gates the dummy-instruction inserter and periodically reseeds its LFSR from entropy.
// Optional statistics counter enabled by defining IBEX_DUMMY_RESEED_STAT_EN.
module ibex_dummy_reseed_ctrl
  import ibex_dummy_reseed_ctrl_pkg::*;
#(
  parameter int unsigned RESEED_INTERVAL = 256,
  parameter int unsigned STAT_W          = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  csr_dummy_en_i,
  input  logic [2:0]            csr_dummy_mask_i,
  input  logic                  csr_seed_wr_i,
  input  logic [DummySeedW-1:0] csr_seed_i,
  input  logic                  debug_mode_i,
  input  logic                  insert_dummy_instr_i,
  input  logic                  id_in_ready_i,
  output logic                  ent_req_o,
  input  logic                  ent_ack_i,
  input  logic [DummySeedW-1:0] ent_data_i,
  output logic                  dummy_instr_en_o,
  output logic [2:0]            dummy_instr_mask_o,
  output logic                  dummy_instr_seed_en_o,
  output logic [DummySeedW-1:0] dummy_instr_seed_o,
  output logic                  reseed_busy_o,
  output logic [STAT_W-1:0]     dummy_stat_o
);

  localparam int unsigned     CntW   = $clog2(RESEED_INTERVAL + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(RESEED_INTERVAL);

  localparam logic [1:0] StIdle  = RESEED_IDLE;
  localparam logic [1:0] StReq   = RESEED_REQ;
  localparam logic [1:0] StApply = RESEED_APPLY;

  logic                  accept_s;
  logic                  cnt_inc_s;
  logic                  cnt_clr_s;
  logic                  cnt_tc_s;
  logic                  auto_load_s;
  logic                  seed_en_d_s;
  logic                  apply_done_r;
  logic [1:0]            state_r;
  logic [1:0]            state_d_s;
  logic [CntW-1:0]       cnt_s;
  logic [DummySeedW-1:0] ent_r;
  logic [DummySeedW-1:0] seed_d_s;

  assign accept_s  = insert_dummy_instr_i & id_in_ready_i;
  assign cnt_inc_s = accept_s & (state_r == StIdle);
  assign cnt_clr_s = seed_en_d_s;
  assign cnt_tc_s  = (cnt_s == CntMax);

  ibex_dummy_reseed_cnt #(
    .Width  (CntW),
    .MaxVal (CntMax)
  ) u_interval_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (cnt_inc_s),
    .clr   (cnt_clr_s),
    .count (cnt_s)
  );

  // The automatic strobe is owed on ack, or later if a software write took its slot.
  assign auto_load_s = ((state_r == StReq) & ent_ack_i |
                        (state_r == StApply) & ~apply_done_r) & ~csr_seed_wr_i;
  assign seed_en_d_s = csr_seed_wr_i | auto_load_s;

  // Reseed FSM next-state.
  always_comb begin
    state_d_s = state_r;
    case (state_r)
      StIdle: begin
        if (cnt_tc_s && csr_dummy_en_i) begin
          state_d_s = StReq;
        end else begin
          state_d_s = StIdle;
        end
      end
      StReq: begin
        if (ent_ack_i) begin
          state_d_s = StApply;
        end else begin
          state_d_s = StReq;
        end
      end
      StApply: begin
        if (apply_done_r) begin
          state_d_s = StIdle;
        end else begin
          state_d_s = StApply;
        end
      end
      default: state_d_s = StIdle;
    endcase
  end

  // Seed source: software wins, then fresh entropy on the ack cycle, else the captured word.
  always_comb begin
    seed_d_s = ent_r;
    if (csr_seed_wr_i) begin
      seed_d_s = csr_seed_i;
    end else if (state_r == StReq) begin
      seed_d_s = ent_data_i;
    end else begin
      seed_d_s = ent_r;
    end
  end

  // State and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r               <= StIdle;
      apply_done_r          <= 1'b0;
      ent_r                 <= '0;
      ent_req_o             <= 1'b0;
      reseed_busy_o         <= 1'b0;
      dummy_instr_en_o      <= 1'b0;
      dummy_instr_mask_o    <= 3'b000;
      dummy_instr_seed_en_o <= 1'b0;
      dummy_instr_seed_o    <= '0;
    end else begin
      state_r               <= state_d_s;
      apply_done_r          <= auto_load_s;
      ent_req_o             <= (state_d_s == StReq);
      reseed_busy_o         <= (state_d_s != StIdle);
      dummy_instr_en_o      <= csr_dummy_en_i & ~debug_mode_i & ~seed_en_d_s;
      dummy_instr_mask_o    <= csr_dummy_mask_i;
      dummy_instr_seed_en_o <= seed_en_d_s;
      if ((state_r == StReq) && ent_ack_i) begin
        ent_r <= ent_data_i;
      end
      if (seed_en_d_s) begin
        dummy_instr_seed_o <= seed_d_s;
      end
    end
  end

`ifdef IBEX_DUMMY_RESEED_STAT_EN
  ibex_dummy_reseed_cnt #(
    .Width  (STAT_W),
    .MaxVal ({STAT_W{1'b1}})
  ) u_stat_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (accept_s),
    .clr   (1'b0),
    .count (dummy_stat_o)
  );
`else
  assign dummy_stat_o = '0;
`endif

endmodule
